// File: rtl/interface_tag_pkg.sv
// Shared types and defaults for the OpenCAPI tag pool.
// Holds the pool state encoding and the per-tag context layout.
package interface_tag_pkg;

  localparam int TAG_DEF    = 256;
  localparam int NSTRMS_DEF = 64;
  localparam int L2_NCL_DEF = 256;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [$clog2(NSTRMS_DEF)-1:0] sid;
    logic [$clog2(L2_NCL_DEF)-1:0] ptr;
  } tag_ctx_t;

endpackage

// File: rtl/interface_tag_freelist.sv
// Circular FIFO of free tags with wrap-around pointers and a count.
// Never overflows: only outstanding tags are ever pushed back.
module interface_tag_freelist
  import interface_tag_pkg::*;
#(
  parameter int tag       = TAG_DEF,
  parameter int tag_width = $clog2(tag)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [tag_width-1:0] push_tag,
  input  logic                 pop,
  output logic [tag_width-1:0] head,
  output logic [tag_width:0]   cnt
);

  logic [tag_width-1:0] mem_q [tag];
  logic [tag_width-1:0] rd_q, rd_d;
  logic [tag_width-1:0] wr_q, wr_d;
  logic [tag_width:0]   cnt_q, cnt_d;

  // Pointer and count update for push/pop
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Tag storage, refilled by INIT so it needs no reset
  always_ff @(posedge clk) begin
    if (!reset && push) mem_q[wr_q] <= push_tag;
  end

  assign head = mem_q[rd_q];
  assign cnt  = cnt_q;

endmodule

// File: rtl/interface_tag_pool.sv
// Tag pool: grants free tags to requests, stores their context,
// and returns the context when the response tag comes back.
module interface_tag_pool
  import interface_tag_pkg::*;
#(
  parameter int tag          = TAG_DEF,
  parameter int tag_width    = $clog2(tag),
  parameter int nstrms       = NSTRMS_DEF,
  parameter int nstrms_width = $clog2(nstrms),
  parameter int l2_ncl       = L2_NCL_DEF,
  parameter int l2_ncl_width = $clog2(l2_ncl)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_alloc_v,
  output logic                    o_alloc_r,
  input  logic [nstrms_width-1:0] i_alloc_sid,
  input  logic [l2_ncl_width-1:0] i_alloc_ptr,
  output logic [tag_width-1:0]    o_alloc_tag,
  input  logic                    i_rel_v,
  output logic                    o_rel_r,
  input  logic [tag_width-1:0]    i_rel_tag,
  output logic                    o_rsp_v,
  input  logic                    i_rsp_r,
  output logic [tag_width-1:0]    o_rsp_tag,
  output logic [nstrms_width-1:0] o_rsp_sid,
  output logic [l2_ncl_width-1:0] o_rsp_ptr,
  output logic [tag_width:0]      o_free_cnt,
  output logic                    o_busy,
  output logic                    o_err
);

  typedef struct packed {
    logic [nstrms_width-1:0] sid;
    logic [l2_ncl_width-1:0] ptr;
  } ctx_t;

  state_e               state_q, state_d;
  logic [tag_width-1:0] k_q, k_d;
  logic [tag-1:0]       outs_q, outs_d;
  ctx_t                 ctx_mem_q [tag];

  logic                 rsp_v_q, rsp_v_d;
  logic [tag_width-1:0] rsp_tag_q, rsp_tag_d;
  ctx_t                 rsp_ctx_q, rsp_ctx_d;
  logic                 err_q, err_d;

  logic                 fl_push;
  logic [tag_width-1:0] fl_tag;
  logic [tag_width-1:0] fl_head;
  logic [tag_width:0]   fl_cnt;
  logic                 run;
  logic                 alloc_fire;
  logic                 rel_fire;

  assign run        = (state_q == RUN);
  assign o_alloc_r  = run && (fl_cnt != '0);
  assign o_rel_r    = run && (!rsp_v_q || i_rsp_r);
  assign alloc_fire = i_alloc_v && o_alloc_r;
  assign rel_fire   = i_rel_v && o_rel_r;

  interface_tag_freelist #(
    .tag       (tag),
    .tag_width (tag_width)
  ) u_freelist (
    .clk      (clk),
    .reset    (reset),
    .push     (fl_push),
    .push_tag (fl_tag),
    .pop      (alloc_fire),
    .head     (fl_head),
    .cnt      (fl_cnt)
  );

  // INIT sweep, outstanding tracking, result stage and error flag
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    outs_d    = outs_q;
    rsp_v_d   = rsp_v_q;
    rsp_tag_d = rsp_tag_q;
    rsp_ctx_d = rsp_ctx_q;
    err_d     = err_q;
    fl_push   = 1'b0;
    fl_tag    = k_q;
    if (rsp_v_q && i_rsp_r) rsp_v_d = 1'b0;
    unique case (state_q)
      INIT: begin
        fl_push = 1'b1;
        fl_tag  = k_q;
        k_d     = k_q + 1'b1;
        outs_d  = '0;
        if (k_q == tag_width'(tag - 1)) state_d = RUN;
      end
      RUN: begin
        if (alloc_fire) outs_d[fl_head] = 1'b1;
        if (rel_fire) begin
          if (outs_q[i_rel_tag]) begin
            outs_d[i_rel_tag] = 1'b0;
            fl_push   = 1'b1;
            fl_tag    = i_rel_tag;
            rsp_v_d   = 1'b1;
            rsp_tag_d = i_rel_tag;
            rsp_ctx_d = ctx_mem_q[i_rel_tag];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= INIT;
      k_q       <= '0;
      outs_q    <= '0;
      rsp_v_q   <= 1'b0;
      rsp_tag_q <= '0;
      rsp_ctx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      outs_q    <= outs_d;
      rsp_v_q   <= rsp_v_d;
      rsp_tag_q <= rsp_tag_d;
      rsp_ctx_q <= rsp_ctx_d;
      err_q     <= err_d;
    end
  end

  // Context RAM written on each granted allocation
  always_ff @(posedge clk) begin
    if (!reset && alloc_fire) ctx_mem_q[fl_head] <= {i_alloc_sid, i_alloc_ptr};
  end

  assign o_alloc_tag = run ? fl_head : '0;
  assign o_rsp_v     = rsp_v_q;
  assign o_rsp_tag   = rsp_tag_q;
  assign o_rsp_sid   = rsp_ctx_q.sid;
  assign o_rsp_ptr   = rsp_ctx_q.ptr;
  assign o_free_cnt  = fl_cnt;
  assign o_busy      = (state_q == INIT);
  assign o_err       = err_q;

endmodule

// File: tb/tb_interface_tag_pool.sv
// Scoreboard bench for interface_tag_pool with an 8-tag pool.
// A model free list and context table predict grants and results.
module tb_interface_tag_pool;

  localparam int T = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_alloc_v;
  logic       o_alloc_r;
  logic [5:0] i_alloc_sid;
  logic [7:0] i_alloc_ptr;
  logic [2:0] o_alloc_tag;
  logic       i_rel_v;
  logic       o_rel_r;
  logic [2:0] i_rel_tag;
  logic       o_rsp_v;
  logic       i_rsp_r;
  logic [2:0] o_rsp_tag;
  logic [5:0] o_rsp_sid;
  logic [7:0] o_rsp_ptr;
  logic [3:0] o_free_cnt;
  logic       o_busy;
  logic       o_err;

  typedef struct {
    int t;
    int s;
    int p;
  } rsp_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   free_q[$];
  rsp_t exp_rsp[$];
  bit   outs[T];
  int   m_sid[T];
  int   m_ptr[T];

  interface_tag_pool #(
    .tag    (T),
    .nstrms (64),
    .l2_ncl (256)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_alloc_v   (i_alloc_v),
    .o_alloc_r   (o_alloc_r),
    .i_alloc_sid (i_alloc_sid),
    .i_alloc_ptr (i_alloc_ptr),
    .o_alloc_tag (o_alloc_tag),
    .i_rel_v     (i_rel_v),
    .o_rel_r     (o_rel_r),
    .i_rel_tag   (i_rel_tag),
    .o_rsp_v     (o_rsp_v),
    .i_rsp_r     (i_rsp_r),
    .o_rsp_tag   (o_rsp_tag),
    .o_rsp_sid   (o_rsp_sid),
    .o_rsp_ptr   (o_rsp_ptr),
    .o_free_cnt  (o_free_cnt),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    free_q.delete();
    exp_rsp.delete();
    for (int i = 0; i < T; i++) begin
      free_q.push_back(i);
      outs[i] = 1'b0;
    end
  endtask

  task automatic check_rst_vals(input string tagn);
    n_cmp++;
    if ({o_busy, o_alloc_r, o_alloc_tag, o_rel_r, o_rsp_v, o_err} !== 8'b1000_0000) begin
      n_err++;
      $display("FAIL %s_ctl got busy=%0b ar=%0b at=%0d rr=%0b rv=%0b err=%0b exp 1 0 0 0 0 0",
               tagn, o_busy, o_alloc_r, o_alloc_tag, o_rel_r, o_rsp_v, o_err);
    end
    n_cmp++;
    if ({o_rsp_tag, o_rsp_sid, o_rsp_ptr, o_free_cnt} !== 21'd0) begin
      n_err++;
      $display("FAIL %s_data got tag=%0d sid=%0d ptr=%0d cnt=%0d exp all 0",
               tagn, o_rsp_tag, o_rsp_sid, o_rsp_ptr, o_free_cnt);
    end
  endtask

  task automatic check_init_len(input string tagn);
    for (int c = 0; c < T; c++) begin
      n_cmp++;
      if (o_alloc_r !== 1'b0 || o_busy !== 1'b1) begin
        n_err++;
        $display("FAIL %s_cyc%0d got ar=%0b busy=%0b exp ar=0 busy=1", tagn, c, o_alloc_r, o_busy);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({o_busy, o_alloc_r, o_alloc_tag, o_free_cnt} !== {1'b0, 1'b1, 3'd0, 4'd8}) begin
      n_err++;
      $display("FAIL %s_done got busy=%0b ar=%0b tag=%0d cnt=%0d exp 0 1 0 8",
               tagn, o_busy, o_alloc_r, o_alloc_tag, o_free_cnt);
    end
  endtask

  task automatic do_alloc(input int sid, input int ptr, output int got);
    int n;
    int e;
    n = 0;
    got = -1;
    i_alloc_v = 1'b1;
    i_alloc_sid = 6'(sid);
    i_alloc_ptr = 8'(ptr);
    @(negedge clk);
    while (!o_alloc_r && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (!o_alloc_r || free_q.size() == 0) begin
      n_err++;
      $display("FAIL alloc_ready got ar=%0b model_free=%0d exp ar=1", o_alloc_r, free_q.size());
    end else begin
      n_cmp++;
      if (o_free_cnt !== 4'(free_q.size())) begin
        n_err++;
        $display("FAIL alloc_cnt got=%0d exp=%0d", o_free_cnt, free_q.size());
      end
      e = free_q.pop_front();
      got = int'(o_alloc_tag);
      n_cmp++;
      if (o_alloc_tag !== 3'(e)) begin
        n_err++;
        $display("FAIL alloc_tag got=%0d exp=%0d", o_alloc_tag, e);
      end
      outs[e] = 1'b1;
      m_sid[e] = sid;
      m_ptr[e] = ptr;
    end
    @(posedge clk);
    #1;
    i_alloc_v = 1'b0;
  endtask

  task automatic check_rsp(input string tagn);
    rsp_t e;
    n_cmp++;
    if (o_rsp_v !== 1'b1 || exp_rsp.size() == 0) begin
      n_err++;
      $display("FAIL %s_v got=%0b exp=1 (queued %0d)", tagn, o_rsp_v, exp_rsp.size());
    end else begin
      e = exp_rsp.pop_front();
      n_cmp++;
      if ({o_rsp_tag, o_rsp_sid, o_rsp_ptr} !== {3'(e.t), 6'(e.s), 8'(e.p)}) begin
        n_err++;
        $display("FAIL %s_data got tag=%0d sid=%0d ptr=%0h exp tag=%0d sid=%0d ptr=%0h",
                 tagn, o_rsp_tag, o_rsp_sid, o_rsp_ptr, e.t, e.s, e.p);
      end
    end
  endtask

  task automatic model_release(input int t, output bit legal);
    legal = outs[t];
    if (legal) begin
      outs[t] = 1'b0;
      free_q.push_back(t);
      exp_rsp.push_back('{t, m_sid[t], m_ptr[t]});
    end
  endtask

  task automatic do_release(input int t);
    int n;
    bit legal;
    n = 0;
    i_rel_v = 1'b1;
    i_rel_tag = 3'(t);
    @(negedge clk);
    while (!o_rel_r && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (!o_rel_r) begin
      n_err++;
      $display("FAIL rel_ready tag=%0d got=0 exp=1", t);
    end
    model_release(t, legal);
    @(posedge clk);
    #1;
    i_rel_v = 1'b0;
    @(negedge clk);
    if (legal) begin
      check_rsp("rel_rsp");
    end else begin
      n_cmp++;
      if (o_rsp_v !== 1'b0 || o_err !== 1'b1) begin
        n_err++;
        $display("FAIL rel_illegal got rv=%0b err=%0b exp rv=0 err=1", o_rsp_v, o_err);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_alloc_v = 1'b1;
    i_alloc_sid = '0;
    i_alloc_ptr = '0;
    i_rel_v = 1'b0;
    i_rel_tag = '0;
    i_rsp_r = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_rst_vals("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_init_len("init");
    i_alloc_v = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_exhaust();
    int g;
    for (int i = 0; i < T; i++) do_alloc(i, 8'h10 + i, g);
    i_alloc_v = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (o_alloc_r !== 1'b0 || o_free_cnt !== 4'd0) begin
        n_err++;
        $display("FAIL exhaust_stall got ar=%0b cnt=%0d exp ar=0 cnt=0", o_alloc_r, o_free_cnt);
      end
      @(posedge clk);
      #1;
    end
    i_alloc_v = 1'b0;
  endtask

  task automatic test_context();
    int g;
    int order[7] = '{0, 1, 2, 4, 5, 6, 7};
    foreach (order[i]) do_release(order[i]);
    do_release(3);
    @(negedge clk);
    n_cmp++;
    if (o_free_cnt !== 4'd8) begin
      n_err++;
      $display("FAIL ctx_full got=%0d exp=8", o_free_cnt);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 7; i++) do_alloc(i + 8, 8'h40 + i, g);
    do_alloc(1, 8'h2A, g);
    n_cmp++;
    if (g != 3) begin
      n_err++;
      $display("FAIL ctx_after7 got=%0d exp=3", g);
    end
    do_release(3);
  endtask

  task automatic test_simul_bp();
    int g;
    int e;
    bit legal;
    do_alloc(2, 8'h33, g);
    i_alloc_v = 1'b1;
    i_alloc_sid = 6'd20;
    i_alloc_ptr = 8'h55;
    i_rel_v = 1'b1;
    i_rel_tag = 3'd5;
    @(negedge clk);
    n_cmp++;
    if (o_alloc_r !== 1'b0 || o_rel_r !== 1'b1) begin
      n_err++;
      $display("FAIL simul_nobypass got ar=%0b rr=%0b exp ar=0 rr=1", o_alloc_r, o_rel_r);
    end
    model_release(5, legal);
    @(posedge clk);
    #1;
    i_rel_v = 1'b0;
    @(negedge clk);
    e = free_q.pop_front();
    n_cmp++;
    if (o_alloc_r !== 1'b1 || o_alloc_tag !== 3'd5 || e != 5) begin
      n_err++;
      $display("FAIL simul_regrant got ar=%0b tag=%0d exp ar=1 tag=5", o_alloc_r, o_alloc_tag);
    end
    outs[5] = 1'b1;
    m_sid[5] = 20;
    m_ptr[5] = 8'h55;
    check_rsp("simul_rsp");
    @(posedge clk);
    #1;
    i_alloc_v = 1'b0;
    i_rsp_r = 1'b0;
    i_rel_v = 1'b1;
    i_rel_tag = 3'd0;
    @(negedge clk);
    n_cmp++;
    if (o_rel_r !== 1'b1) begin
      n_err++;
      $display("FAIL bp_first got=%0b exp=1", o_rel_r);
    end
    model_release(0, legal);
    @(posedge clk);
    #1;
    i_rel_tag = 3'd1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (o_rel_r !== 1'b0 || o_rsp_v !== 1'b1) begin
        n_err++;
        $display("FAIL bp_hold got rr=%0b rv=%0b exp rr=0 rv=1", o_rel_r, o_rsp_v);
      end
      @(posedge clk);
      #1;
    end
    i_rsp_r = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (o_rel_r !== 1'b1) begin
      n_err++;
      $display("FAIL bp_drain_accept got=%0b exp=1", o_rel_r);
    end
    check_rsp("bp_rsp0");
    model_release(1, legal);
    @(posedge clk);
    #1;
    i_rel_v = 1'b0;
    @(negedge clk);
    check_rsp("bp_rsp1");
    @(posedge clk);
    #1;
    i_alloc_v = 1'b1;
    i_alloc_sid = 6'd33;
    i_alloc_ptr = 8'h77;
    i_rel_v = 1'b1;
    i_rel_tag = 3'd2;
    @(negedge clk);
    e = free_q.pop_front();
    n_cmp++;
    if (o_alloc_r !== 1'b1 || o_rel_r !== 1'b1 || o_alloc_tag !== 3'(e)) begin
      n_err++;
      $display("FAIL both_fire got ar=%0b rr=%0b tag=%0d exp 1 1 %0d", o_alloc_r, o_rel_r, o_alloc_tag, e);
    end
    outs[e] = 1'b1;
    m_sid[e] = 33;
    m_ptr[e] = 8'h77;
    model_release(2, legal);
    @(posedge clk);
    #1;
    i_alloc_v = 1'b0;
    i_rel_v = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (o_free_cnt !== 4'(free_q.size()) || free_q.size() != 2) begin
      n_err++;
      $display("FAIL both_cnt got=%0d exp=2", o_free_cnt);
    end
    check_rsp("both_rsp");
    @(posedge clk);
    #1;
  endtask

  task automatic test_illegal();
    int cnt0;
    do_release(6);
    cnt0 = free_q.size();
    do_release(6);
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (o_err !== 1'b1 || o_rsp_v !== 1'b0 || o_free_cnt !== 4'(cnt0)) begin
        n_err++;
        $display("FAIL illegal_hold got err=%0b rv=%0b cnt=%0d exp 1 0 %0d", o_err, o_rsp_v, o_free_cnt, cnt0);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_mid_reset();
    int g;
    while (free_q.size() > 3) do_alloc(40, 8'h99, g);
    while (free_q.size() < 3) begin
      for (int i = 0; i < T; i++) begin
        if (outs[i]) begin
          do_release(i);
          break;
        end
      end
    end
    i_rsp_r = 1'b0;
    for (int i = 0; i < T; i++) begin
      if (outs[i]) begin
        do_release(i);
        break;
      end
    end
    @(negedge clk);
    n_cmp++;
    if (o_rsp_v !== 1'b1 || o_free_cnt !== 4'd4) begin
      n_err++;
      $display("FAIL mid_pre got rv=%0b cnt=%0d exp rv=1 cnt=4", o_rsp_v, o_free_cnt);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    i_alloc_v = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    i_rsp_r = 1'b1;
    model_reset();
    @(negedge clk);
    check_rst_vals("mid_rst");
    check_init_len("mid_init");
    i_alloc_v = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < T; i++) do_alloc(i, i, g);
  endtask

  initial begin
    test_reset();
    test_exhaust();
    test_context();
    test_simul_bp();
    test_illegal();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/interface_tag_pool.md
# interface_tag_pool

Tag pool controller for the OpenCAPI 3.0 request path. It owns the set of `tag` transaction tags shared by all streams. It hands one free tag to each outbound request and records that request's stream id and L2 line pointer against the tag. When the matching response tag returns, it gives the tag back to the pool and reports the stored context so the response data can be steered to the right stream buffer line.

## Interface
Parameters:
- `tag`, 256, number of tags; a power of two, at least 4.
- `tag_width`, `$clog2(tag)`, tag index width.
- `nstrms`, 64, number of streams.
- `nstrms_width`, `$clog2(nstrms)`, stream id width.
- `l2_ncl`, 256, number of L2 cache lines.
- `l2_ncl_width`, `$clog2(l2_ncl)`, L2 line pointer width.

Ports:
- `clk`  in  1  Single clock. All logic is on its rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `i_alloc_v`  in  1  Allocation request valid.
- `o_alloc_r`  out  1  A free tag is available and the pool is in RUN.
- `i_alloc_sid`  in  nstrms_width  Stream id to record against the tag.
- `i_alloc_ptr`  in  l2_ncl_width  L2 line pointer to record against the tag.
- `o_alloc_tag`  out  tag_width  Tag granted. Meaningful only while `o_alloc_r`=1.
- `i_rel_v`  in  1  Release valid: this response tag has returned.
- `o_rel_r`  out  1  Release accepted.
- `i_rel_tag`  in  tag_width  Tag being released.
- `o_rsp_v`  out  1  Release result valid.
- `i_rsp_r`  in  1  Downstream is ready for the release result.
- `o_rsp_tag`, `o_rsp_sid`, `o_rsp_ptr`  out  tag_width / nstrms_width / l2_ncl_width  Released tag and its stored context.
- `o_free_cnt`  out  tag_width+1  Number of tags currently free.
- `o_busy`  out  1  High while in INIT.
- `o_err`  out  1  Sticky flag: a tag was released that was not outstanding.

## Operation
- The state machine has two states, INIT and RUN. Reset forces INIT from any state, including in the middle of a transaction.
- **INIT** is a sweep. Counter `k` runs 0..tag-1 and writes tag `k` into the free FIFO, one tag per cycle. The outstanding vector is cleared. When `k`=tag-1, the next state is RUN.
- **Free FIFO** is a circular buffer of depth `tag`.
  - Read and write pointers are tag_width bits wide and wrap naturally.
  - The count is tag_width+1 bits. `o_free_cnt` equals this count.
  - The FIFO cannot overflow, because releases are only accepted for tags that are outstanding.
- **Allocation fire** occurs when `i_alloc_v & o_alloc_r`. On fire:
  - pop the FIFO head;
  - set `outstanding[tag]`;
  - write `{i_alloc_sid, i_alloc_ptr}` into the context RAM at that tag.
- **`o_alloc_r`** = RUN and count≠0. **`o_alloc_tag`** = the FIFO head. Both are driven purely from registers.
- **`o_rel_r`** = RUN & (~`o_rsp_v` | `i_rsp_r`). The result stage is a single-entry output register.
- **Release fire, outstanding tag:**
  - clear `outstanding[tag]`;
  - push the tag into the FIFO;
  - load the result register with the tag and its stored context, and set `o_rsp_v`.
- **Release fire, tag not outstanding:** no push and no result. `o_err` is set to 1 and stays set until reset.
- **Simultaneous allocation and release:** both take effect and the count is unchanged. There is no bypass: with count=0, a release does not make `o_alloc_r` high in the same cycle.
- **Allocation and release of the same tag in the same cycle:** cannot occur, because the head tag is never outstanding.
- **Reset values:**
  - `o_busy`=1;
  - `o_alloc_r`=0, `o_alloc_tag`=0;
  - `o_rel_r`=0;
  - `o_rsp_v`=0, and `o_rsp_tag`, `o_rsp_sid`, `o_rsp_ptr` all 0;
  - `o_free_cnt`=0;
  - `o_err`=0.
- Any allocation or release requests present during INIT are ignored, because their ready signals are 0.

## Timing
- INIT lasts exactly `tag` cycles after the first cycle with `reset`=0. On the cycle after that, `o_busy`=0, `o_alloc_r`=1 and `o_free_cnt`=tag.
- The first allocations after INIT grant tags in order 0, 1, 2, …. After that, tags are granted in release (FIFO) order.
- Allocation latency is zero: the tag is presented in the same cycle as the fire. Pointer and count are updated at the edge.
- Release-to-result latency is 1 cycle. `o_rsp_v` holds until `i_rsp_r`. A new release can be accepted in the same cycle that the current result drains.
- A released tag becomes allocatable no earlier than the cycle after its release fire.
- Context RAM: write on allocation and read on release, both synchronous. A release of tag T can follow T's allocation by 1 cycle or more and must return the new context.

## Structure
- Package `interface_tag_pkg`:
  - default values for `tag`, `nstrms` and `l2_ncl`;
  - state enum `{INIT, RUN}`;
  - a packed context struct `{sid, ptr}`.
- Sub-module `interface_tag_freelist`: the circular FIFO with its pointers, count, push and pop. The top level holds the state machine, the outstanding vector, the context RAM, the result register and the error flag.

## Test plan
All scenarios use `tag`=8.
- **Reset and INIT:** deassert reset and hold `i_alloc_v`=1 → `o_alloc_r`=0 for 8 cycles, then `o_alloc_r`=1 with `o_alloc_tag`=0 and `o_free_cnt`=8.
- **Exhaust and in-order grant:** allocate 8 times back-to-back → tags 0..7 are granted and `o_free_cnt` reaches 0. A 9th request stalls with `o_alloc_r`=0.
- **Context return and FIFO reuse:** allocate tag 3 with sid=1, ptr=0x2A, then release 3 → one cycle later `o_rsp_v`=1 with tag=3, sid=1, ptr=0x2A. After the pool is full, the next grant following tag 7 is tag 3.
- **Simultaneous alloc, release and backpressure:** with count=0, release tag 5 and request an allocation in the same cycle → no allocation that cycle; the next cycle grants tag 5. With `i_rsp_r`=0 and `o_rsp_v`=1, `o_rel_r`=0 until `i_rsp_r`=1.
- **Illegal release:** release tag 6 while it is not outstanding → `o_err`=1 and stays 1, no `o_rsp_v`, `o_free_cnt` unchanged.
- **Reset mid-operation:** assert reset for 1 cycle with 4 tags outstanding and `o_rsp_v`=1 → all outputs return to their reset values, and INIT repeats with the same 8-cycle length and tag order 0..7.
